// File: rtl/exti_pkg.sv
// exti_pkg: shared edge-select encodings and request FSM states for the EXTI receiver
package exti_pkg;
  localparam logic [1:0] EDGE_NONE = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;
  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;
endpackage

// File: rtl/exti_debounce.sv
// exti_debounce: synchronises the async pin, debounces it and strobes the accepted edges
module exti_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = 18,
  parameter logic RST_LEVEL = 1'b0
) (
  input  logic clk25,
  input  logic fpga_rst_n,
  input  logic exti_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s, done;
  logic [CNT_W-1:0] cnt;
  // done is high on the clock edge that commits the new level
  assign done = (s != level) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise = done && s;
  assign fall = done && !s;
  always_ff @(posedge clk25 or negedge fpga_rst_n)
    if (!fpga_rst_n) begin
      s1 <= RST_LEVEL;
      s <= RST_LEVEL;
      level <= RST_LEVEL;
      cnt <= '0;
    end else begin
      s1 <= exti_in;
      s <= s1;
      cnt <= (s == level || done) ? '0 : cnt + 1'b1;
      if (done) level <= s;
    end
endmodule

// File: rtl/exti_edge_rx.sv
// exti_edge_rx: debounced external-interrupt receiver with held request, event count and overrun
module exti_edge_rx
  import exti_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W = 18,
  parameter int EVT_W = 16,
  parameter logic RST_LEVEL = 1'b0
) (
  input  logic clk25,
  input  logic fpga_rst_n,
  input  logic exti_in,
  input  logic [1:0] edge_sel,
  input  logic irq_en,
  input  logic irq_ack,
  output logic irq_req,
  output logic irq_pulse,
  output logic exti_level,
  output logic [EVT_W-1:0] event_cnt,
  output logic overrun
);
  logic rise, fall, qe;
  state_t st;
  exti_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W),
    .RST_LEVEL(RST_LEVEL)
  ) u_deb (
    .clk25(clk25),
    .fpga_rst_n(fpga_rst_n),
    .exti_in(exti_in),
    .level(exti_level),
    .rise(rise),
    .fall(fall)
  );
  assign qe = (rise && |(edge_sel & EDGE_RISE)) || (fall && |(edge_sel & EDGE_FALL));
  assign irq_req = st == ST_PEND;
  // a pending request survives unless acked; any qualified, enabled edge (re)arms it
  always_ff @(posedge clk25 or negedge fpga_rst_n)
    if (!fpga_rst_n) begin
      st <= ST_IDLE;
      irq_pulse <= 1'b0;
      event_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      irq_pulse <= qe;
      event_cnt <= event_cnt + EVT_W'(qe);
      st <= ((st == ST_PEND && !irq_ack) || (qe && irq_en)) ? ST_PEND : ST_IDLE;
      overrun <= (st == ST_PEND) && !irq_ack && (overrun || qe);
    end
endmodule

// File: tb/tb_exti_edge_rx.sv
// tb_exti_edge_rx: directed stimulus checked every cycle against a window-based behavioural model
module tb_exti_edge_rx;
  import exti_pkg::*;
  localparam int DC = 16;
  localparam int EW = 4;
  logic clk25 = 1'b0, fpga_rst_n = 1'b0, exti_in = 1'b0, irq_en = 1'b1, irq_ack = 1'b0;
  logic [1:0] edge_sel = EDGE_RISE;
  logic irq_req, irq_pulse, exti_level, overrun;
  logic [EW-1:0] event_cnt;
  int tests = 0, fails = 0, pulses = 0, reqs = 0, p0, r0;
  bit m_lvl, m_pulse, m_req, m_ovr, m_s, m_flip, m_qe;
  int m_cnt;
  bit pin_q[$];
  bit win[$];

  always #20 clk25 = ~clk25;

  exti_edge_rx #(.DEBOUNCE_CYCLES(DC), .CNT_W(5), .EVT_W(EW), .RST_LEVEL(1'b0)) dut (
    .clk25(clk25), .fpga_rst_n(fpga_rst_n), .exti_in(exti_in), .edge_sel(edge_sel),
    .irq_en(irq_en), .irq_ack(irq_ack), .irq_req(irq_req), .irq_pulse(irq_pulse),
    .exti_level(exti_level), .event_cnt(event_cnt), .overrun(overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk25);
  endtask

  // Model: the pin reaches the logic two samples late; the level flips once the
  // last DC synced samples all disagree with it.
  initial forever begin
    @(posedge clk25 or negedge fpga_rst_n);
    if (!fpga_rst_n) begin
      m_lvl = 0; m_pulse = 0; m_req = 0; m_ovr = 0; m_cnt = 0;
      pin_q = '{0, 0};
      win = {};
    end else begin
      m_s = pin_q.pop_front();
      pin_q.push_back(exti_in);
      win.push_back(m_s);
      if (win.size() > DC) void'(win.pop_front());
      m_flip = win.size() == DC;
      foreach (win[i]) if (win[i] == m_lvl) m_flip = 0;
      m_qe = m_flip && ((!m_lvl && (edge_sel == EDGE_RISE || edge_sel == EDGE_BOTH)) ||
                        (m_lvl && (edge_sel == EDGE_FALL || edge_sel == EDGE_BOTH)));
      if (m_flip) m_lvl = !m_lvl;
      m_pulse = m_qe;
      if (m_qe) m_cnt = (m_cnt + 1) % (1 << EW);
      if (m_req && !irq_ack) begin
        if (m_qe) m_ovr = 1;
      end else begin
        m_req = m_qe && irq_en;
        m_ovr = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk25);
    #1;
    check("model_level", exti_level, m_lvl);
    check("model_pulse", irq_pulse, m_pulse);
    check("model_req", irq_req, m_req);
    check("model_overrun", overrun, m_ovr);
    check("model_cnt", event_cnt, m_cnt);
    pulses += int'(irq_pulse);
    reqs += int'(irq_req);
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    cyc(3);
    check("rst_level", exti_level, 0);
    check("rst_req", irq_req, 0);
    check("rst_pulse", irq_pulse, 0);
    check("rst_cnt", event_cnt, 0);
    check("rst_overrun", overrun, 0);
    fpga_rst_n = 1'b1;
    cyc(3);
    p0 = pulses;
    exti_in = 1'b1; cyc(10); exti_in = 1'b0; cyc(30);
    check("glitch_level", exti_level, 0);
    check("glitch_pulses", pulses - p0, 0);
    check("glitch_cnt", event_cnt, 0);
    exti_in = 1'b1; cyc(17);
    check("rise_lat17", exti_level, 0);
    cyc(1);
    check("rise_lat18", exti_level, 1);
    check("rise_pulse", irq_pulse, 1);
    check("rise_req", irq_req, 1);
    check("rise_cnt", event_cnt, 1);
    cyc(1);
    check("rise_pulse_1cyc", irq_pulse, 0);
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
    check("ack_req", irq_req, 0);
    edge_sel = EDGE_BOTH;
    exti_in = 1'b0; cyc(25);
    exti_in = 1'b1; cyc(25);
    check("both_cnt", event_cnt, 3);
    check("both_req", irq_req, 1);
    check("both_overrun", overrun, 1);
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
    check("both_ack_req", irq_req, 0);
    check("both_ack_overrun", overrun, 0);
    exti_in = 1'b0; cyc(25);
    exti_in = 1'b1; cyc(25);
    check("sim_pre_overrun", overrun, 1);
    exti_in = 1'b0; cyc(17);
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
    check("sim_pulse", irq_pulse, 1);
    check("sim_req", irq_req, 1);
    check("sim_overrun", overrun, 0);
    check("sim_cnt", event_cnt, 6);
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
    check("sim_ack_req", irq_req, 0);
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0; cyc(2);
    check("idle_ack_req", irq_req, 0);
    irq_en = 1'b0; edge_sel = EDGE_RISE;
    fpga_rst_n = 1'b0; cyc(2); fpga_rst_n = 1'b1; cyc(3);
    check("wrap_start_cnt", event_cnt, 0);
    p0 = pulses; r0 = reqs;
    repeat (17) begin
      exti_in = 1'b1; cyc(20);
      exti_in = 1'b0; cyc(20);
    end
    check("wrap_cnt", event_cnt, 1);
    check("wrap_pulses", pulses - p0, 17);
    check("wrap_reqs", reqs - r0, 0);
    exti_in = 1'b1; cyc(10);
    fpga_rst_n = 1'b0; cyc(1);
    check("midrst_level", exti_level, 0);
    check("midrst_cnt", event_cnt, 0);
    check("midrst_req", irq_req, 0);
    check("midrst_pulse", irq_pulse, 0);
    check("midrst_overrun", overrun, 0);
    irq_en = 1'b1;
    cyc(2);
    p0 = pulses;
    fpga_rst_n = 1'b1;
    cyc(17);
    check("midrst_lat17", exti_level, 0);
    cyc(1);
    check("midrst_lat18", exti_level, 1);
    check("midrst_rise_pulse", irq_pulse, 1);
    cyc(30);
    check("midrst_pulses", pulses - p0, 1);
    check("midrst_req_after", irq_req, 1);
    check("midrst_cnt_after", event_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
